// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one ram between requesters A and B, with in-order owner-tag FIFOs
// per channel. Define ARB_ADDR_CHECK_EN to store issued addresses and flag mismatched returns.
module ram_arbiter #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  // Requester A
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_address,
  input  logic [DW-1:0] a_data,
  output logic          a_gnt,
  output logic          a_wr_done,
  output logic          a_rd_valid,
  output logic [DW-1:0] a_rd_data,
  output logic [AW-1:0] a_ret_address,
  // Requester B
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_address,
  input  logic [DW-1:0] b_data,
  output logic          b_gnt,
  output logic          b_wr_done,
  output logic          b_rd_valid,
  output logic [DW-1:0] b_rd_data,
  output logic [AW-1:0] b_ret_address,
  // Ram side
  output logic [AW-1:0] wr_address,
  output logic          wr_en,
  output logic [DW-1:0] wr_data,
  output logic [AW-1:0] rd_address,
  output logic          rd_en,
  input  logic          wr_ret_ack,
  input  logic [AW-1:0] wr_ret_address,
  input  logic          rd_ret_ack,
  input  logic [AW-1:0] rd_ret_address,
  input  logic [DW-1:0] rd_ret_data,
`ifdef ARB_ADDR_CHECK_EN
  output logic          spurious_err,
  output logic          addr_mismatch_err
`else
  output logic          spurious_err
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // Entry bit 0 is the owner (0 = A, 1 = B); upper bits hold the issued address if checked.
`ifdef ARB_ADDR_CHECK_EN
  localparam int unsigned EW = AW + 1;
`else
  localparam int unsigned EW = 1;
`endif

  // Channel index 0 = write, 1 = read.
  logic [1:0]    full, push, pop, ack;
  logic          a_elig, b_elig, grant, win_b, win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry [2];

  logic [EW-1:0] fifo_q [2][DEPTH];
  logic [EW-1:0] fifo_d [2][DEPTH];
  logic [PW-1:0] head_q [2];
  logic [PW-1:0] head_d [2];
  logic [PW-1:0] tail_q [2];
  logic [PW-1:0] tail_d [2];
  logic [CW-1:0] count_q [2];
  logic [CW-1:0] count_d [2];

  logic          last_a_q, last_a_d;
  logic          wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [AW-1:0] wr_address_q, wr_address_d, rd_address_q, rd_address_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          a_wr_done_q, a_wr_done_d, b_wr_done_q, b_wr_done_d;
  logic          a_rd_valid_q, a_rd_valid_d, b_rd_valid_q, b_rd_valid_d;
  logic [DW-1:0] a_rd_data_q, a_rd_data_d, b_rd_data_q, b_rd_data_d;
  logic [AW-1:0] a_ret_address_q, a_ret_address_d, b_ret_address_q, b_ret_address_d;
  logic          spurious_err_q, spurious_err_d;
`ifdef ARB_ADDR_CHECK_EN
  logic          addr_mismatch_err_q, addr_mismatch_err_d;
`endif

  // Arbitration and issue muxing.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c] = (count_q[c] == CW'(DEPTH));
    end
    a_elig   = a_req && !(a_we ? full[0] : full[1]);
    b_elig   = b_req && !(b_we ? full[0] : full[1]);
    // On a tie the requester that did not win last time goes first.
    a_gnt    = a_elig && (!b_elig || !last_a_q);
    b_gnt    = b_elig && !a_gnt;
    grant    = a_gnt || b_gnt;
    win_b    = b_gnt;
    win_we   = win_b ? b_we      : a_we;
    win_addr = win_b ? b_address : a_address;
    win_data = win_b ? b_data    : a_data;
    push[0]  = grant && win_we;
    push[1]  = grant && !win_we;
    last_a_d = a_gnt ? 1'b1 : (b_gnt ? 1'b0 : last_a_q);
`ifdef ARB_ADDR_CHECK_EN
    push_entry = {win_addr, win_b};
`else
    push_entry = win_b;
`endif
    wr_en_d      = push[0];
    wr_address_d = push[0] ? win_addr : wr_address_q;
    wr_data_d    = push[0] ? win_data : wr_data_q;
    rd_en_d      = push[1];
    rd_address_d = push[1] ? win_addr : rd_address_q;
  end

  // Tag FIFOs.
  always_comb begin
    ack    = {rd_ret_ack, wr_ret_ack};
    fifo_d = fifo_q;
    for (int c = 0; c < 2; c++) begin
      head_entry[c] = fifo_q[c][head_q[c]];
      pop[c]        = ack[c] && (count_q[c] != '0);
      head_d[c]     = head_q[c];
      tail_d[c]     = tail_q[c];
      count_d[c]    = count_q[c];
      if (push[c]) begin
        fifo_d[c][tail_q[c]] = push_entry;
        tail_d[c]            = tail_q[c] + PW'(1);
      end
      if (pop[c]) begin
        head_d[c] = head_q[c] + PW'(1);
      end
      if (push[c] && !pop[c]) begin
        count_d[c] = count_q[c] + CW'(1);
      end else if (!push[c] && pop[c]) begin
        count_d[c] = count_q[c] - CW'(1);
      end
    end
  end

  // Return routing to the head owner of each channel.
  always_comb begin
    a_wr_done_d     = pop[0] && !head_entry[0][0];
    b_wr_done_d     = pop[0] && head_entry[0][0];
    a_rd_valid_d    = pop[1] && !head_entry[1][0];
    b_rd_valid_d    = pop[1] && head_entry[1][0];
    a_rd_data_d     = a_rd_valid_d ? rd_ret_data : a_rd_data_q;
    b_rd_data_d     = b_rd_valid_d ? rd_ret_data : b_rd_data_q;
    a_ret_address_d = a_ret_address_q;
    b_ret_address_d = b_ret_address_q;
    if (a_wr_done_d) a_ret_address_d = wr_ret_address;
    if (b_wr_done_d) b_ret_address_d = wr_ret_address;
    // A read completing in the same cycle as a write owns the shared return address.
    if (a_rd_valid_d) a_ret_address_d = rd_ret_address;
    if (b_rd_valid_d) b_ret_address_d = rd_ret_address;
    spurious_err_d = spurious_err_q || (ack[0] && !pop[0]) || (ack[1] && !pop[1]);
`ifdef ARB_ADDR_CHECK_EN
    addr_mismatch_err_d = addr_mismatch_err_q
                       || (pop[0] && (head_entry[0][EW-1:1] != wr_ret_address))
                       || (pop[1] && (head_entry[1][EW-1:1] != rd_ret_address));
`endif
  end

  // Storage is not reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        head_q[c]  <= '0;
        tail_q[c]  <= '0;
        count_q[c] <= '0;
      end
      last_a_q        <= 1'b0;
      wr_en_q         <= 1'b0;
      wr_address_q    <= '0;
      wr_data_q       <= '0;
      rd_en_q         <= 1'b0;
      rd_address_q    <= '0;
      a_wr_done_q     <= 1'b0;
      b_wr_done_q     <= 1'b0;
      a_rd_valid_q    <= 1'b0;
      b_rd_valid_q    <= 1'b0;
      a_rd_data_q     <= '0;
      b_rd_data_q     <= '0;
      a_ret_address_q <= '0;
      b_ret_address_q <= '0;
      spurious_err_q  <= 1'b0;
`ifdef ARB_ADDR_CHECK_EN
      addr_mismatch_err_q <= 1'b0;
`endif
    end else begin
      for (int c = 0; c < 2; c++) begin
        head_q[c]  <= head_d[c];
        tail_q[c]  <= tail_d[c];
        count_q[c] <= count_d[c];
      end
      last_a_q        <= last_a_d;
      wr_en_q         <= wr_en_d;
      wr_address_q    <= wr_address_d;
      wr_data_q       <= wr_data_d;
      rd_en_q         <= rd_en_d;
      rd_address_q    <= rd_address_d;
      a_wr_done_q     <= a_wr_done_d;
      b_wr_done_q     <= b_wr_done_d;
      a_rd_valid_q    <= a_rd_valid_d;
      b_rd_valid_q    <= b_rd_valid_d;
      a_rd_data_q     <= a_rd_data_d;
      b_rd_data_q     <= b_rd_data_d;
      a_ret_address_q <= a_ret_address_d;
      b_ret_address_q <= b_ret_address_d;
      spurious_err_q  <= spurious_err_d;
`ifdef ARB_ADDR_CHECK_EN
      addr_mismatch_err_q <= addr_mismatch_err_d;
`endif
    end
  end

  assign wr_en         = wr_en_q;
  assign wr_address    = wr_address_q;
  assign wr_data       = wr_data_q;
  assign rd_en         = rd_en_q;
  assign rd_address    = rd_address_q;
  assign a_wr_done     = a_wr_done_q;
  assign b_wr_done     = b_wr_done_q;
  assign a_rd_valid    = a_rd_valid_q;
  assign b_rd_valid    = b_rd_valid_q;
  assign a_rd_data     = a_rd_data_q;
  assign b_rd_data     = b_rd_data_q;
  assign a_ret_address = a_ret_address_q;
  assign b_ret_address = b_ret_address_q;
  assign spurious_err  = spurious_err_q;
`ifdef ARB_ADDR_CHECK_EN
  assign addr_mismatch_err = addr_mismatch_err_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a vector table for arbitration and return routing, plus
// hand-written sequences for FIFO full, spurious acks and reset with operations in flight.
module tb_ram_arbiter;

  logic        clk, reset;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_address, a_data, b_address, b_data;
  logic        a_gnt, a_wr_done, a_rd_valid, b_gnt, b_wr_done, b_rd_valid;
  logic [15:0] a_rd_data, a_ret_address, b_rd_data, b_ret_address;
  logic [15:0] wr_address, wr_data, rd_address;
  logic        wr_en, rd_en, wr_ret_ack, rd_ret_ack, spurious_err;
  logic [15:0] wr_ret_address, rd_ret_address, rd_ret_data;
`ifdef ARB_ADDR_CHECK_EN
  logic        addr_mismatch_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  ram_arbiter #(.AW(16), .DW(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_address(a_address), .a_data(a_data), .a_gnt(a_gnt),
    .a_wr_done(a_wr_done), .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data),
    .a_ret_address(a_ret_address),
    .b_req(b_req), .b_we(b_we), .b_address(b_address), .b_data(b_data), .b_gnt(b_gnt),
    .b_wr_done(b_wr_done), .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data),
    .b_ret_address(b_ret_address),
    .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data),
    .rd_address(rd_address), .rd_en(rd_en),
    .wr_ret_ack(wr_ret_ack), .wr_ret_address(wr_ret_address),
    .rd_ret_ack(rd_ret_ack), .rd_ret_address(rd_ret_address), .rd_ret_data(rd_ret_data),
`ifdef ARB_ADDR_CHECK_EN
    .spurious_err(spurious_err), .addr_mismatch_err(addr_mismatch_err)
`else
    .spurious_err(spurious_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_req, a_we;
    logic [15:0] a_addr, a_data;
    logic        b_req, b_we;
    logic [15:0] b_addr, b_data;
    logic        wr_ack, rd_ack;
    logic [15:0] wra, rda, rdd;
    logic [1:0]  gnt;      // {a_gnt, b_gnt} in the applied cycle
    logic        wr_en;
    logic [15:0] wr_addr, wr_data;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [3:0]  ret;      // {a_wr_done, b_wr_done, a_rd_valid, b_rd_valid} after the edge
    logic [15:0] a_ret, b_ret, a_rd, b_rd;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;

  task automatic vi(input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                    input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd,
                    input logic wk, input logic rk, input logic [15:0] wa, input logic [15:0] ra,
                    input logic [15:0] rd);
    cur.a_req = ar; cur.a_we = aw; cur.a_addr = aa; cur.a_data = ad;
    cur.b_req = br; cur.b_we = bw; cur.b_addr = ba; cur.b_data = bd;
    cur.wr_ack = wk; cur.rd_ack = rk; cur.wra = wa; cur.rda = ra; cur.rdd = rd;
  endtask

  task automatic ve(input logic [1:0] g, input logic we, input logic [15:0] wad,
                    input logic [15:0] wdt, input logic re, input logic [15:0] rad,
                    input logic [3:0] r, input logic [15:0] ar, input logic [15:0] br,
                    input logic [15:0] ard, input logic [15:0] brd);
    cur.gnt = g; cur.wr_en = we; cur.wr_addr = wad; cur.wr_data = wdt;
    cur.rd_en = re; cur.rd_addr = rad; cur.ret = r;
    cur.a_ret = ar; cur.b_ret = br; cur.a_rd = ard; cur.b_rd = brd;
    tbl.push_back(cur);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    a_req = 0; a_we = 0; a_address = '0; a_data = '0;
    b_req = 0; b_we = 0; b_address = '0; b_data = '0;
    wr_ret_ack = 0; rd_ret_ack = 0; wr_ret_address = '0; rd_ret_address = '0; rd_ret_data = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] drain [4];
    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst wr_en", wr_en, 0);
    chk("rst rd_en", rd_en, 0);
    chk("rst wr_address", wr_address, 0);
    chk("rst ret flags", {a_wr_done, b_wr_done, a_rd_valid, b_rd_valid}, 0);
    chk("rst spurious", spurious_err, 0);
    reset = 1'b0;

    // Alternating reads (A first after reset), then in-order read returns.
    vi(1,0,'h10,0, 1,0,'h20,0, 0,0,0,0,0); ve(2'b10, 0,'h0,'h0, 1,'h10, 4'b0000, 0,0,0,0);
    vi(1,0,'h10,0, 1,0,'h20,0, 0,0,0,0,0); ve(2'b01, 0,'h0,'h0, 1,'h20, 4'b0000, 0,0,0,0);
    vi(1,0,'h10,0, 1,0,'h20,0, 0,0,0,0,0); ve(2'b10, 0,'h0,'h0, 1,'h10, 4'b0000, 0,0,0,0);
    vi(1,0,'h10,0, 1,0,'h20,0, 0,0,0,0,0); ve(2'b01, 0,'h0,'h0, 1,'h20, 4'b0000, 0,0,0,0);
    vi(0,0,0,0, 0,0,0,0, 0,1,0,'h10,'h1234);
    ve(2'b00, 0,'h0,'h0, 0,'h20, 4'b0010, 'h10,'h0,'h1234,'h0);
    vi(0,0,0,0, 0,0,0,0, 0,1,0,'h20,'h5678);
    ve(2'b00, 0,'h0,'h0, 0,'h20, 4'b0001, 'h10,'h20,'h1234,'h5678);
    vi(0,0,0,0, 0,0,0,0, 0,1,0,'h10,'h1111);
    ve(2'b00, 0,'h0,'h0, 0,'h20, 4'b0010, 'h10,'h20,'h1111,'h5678);
    vi(0,0,0,0, 0,0,0,0, 0,1,0,'h20,'h2222);
    ve(2'b00, 0,'h0,'h0, 0,'h20, 4'b0001, 'h10,'h20,'h1111,'h2222);
    // Lone A write and its acknowledge.
    vi(1,1,'h96,'h1, 0,0,0,0, 0,0,0,0,0);
    ve(2'b10, 1,'h96,'h1, 0,'h20, 4'b0000, 'h10,'h20,'h1111,'h2222);
    vi(0,0,0,0, 0,0,0,0, 1,0,'h96,0,0);
    ve(2'b00, 0,'h96,'h1, 0,'h20, 4'b1000, 'h96,'h20,'h1111,'h2222);
    // Mixed write/read contention, then both channels return together.
    vi(1,1,'h30,'hAAAA, 1,0,'h40,0, 0,0,0,0,0);
    ve(2'b01, 0,'h96,'h1, 1,'h40, 4'b0000, 'h96,'h20,'h1111,'h2222);
    vi(1,1,'h30,'hAAAA, 1,0,'h41,0, 0,0,0,0,0);
    ve(2'b10, 1,'h30,'hAAAA, 0,'h40, 4'b0000, 'h96,'h20,'h1111,'h2222);
    vi(0,0,0,0, 0,0,0,0, 1,1,'h30,'h40,'hBEEF);
    ve(2'b00, 0,'h30,'hAAAA, 0,'h40, 4'b1001, 'h30,'h40,'h1111,'hBEEF);
    vi(1,1,'h50,'h5555, 0,0,0,0, 0,0,0,0,0);
    ve(2'b10, 1,'h50,'h5555, 0,'h40, 4'b0000, 'h30,'h40,'h1111,'hBEEF);
    vi(1,0,'h60,0, 0,0,0,0, 0,0,0,0,0);
    ve(2'b10, 0,'h50,'h5555, 1,'h60, 4'b0000, 'h30,'h40,'h1111,'hBEEF);
    vi(0,0,0,0, 0,0,0,0, 1,1,'h50,'h60,'h6666);
    ve(2'b00, 0,'h50,'h5555, 0,'h60, 4'b1010, 'h60,'h40,'h6666,'hBEEF);
    vi(0,0,0,0, 0,0,0,0, 0,0,0,0,0);
    ve(2'b00, 0,'h50,'h5555, 0,'h60, 4'b0000, 'h60,'h40,'h6666,'hBEEF);

    foreach (tbl[i]) begin
      a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_address = tbl[i].a_addr;
      a_data = tbl[i].a_data;
      b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_address = tbl[i].b_addr;
      b_data = tbl[i].b_data;
      wr_ret_ack = tbl[i].wr_ack; rd_ret_ack = tbl[i].rd_ack;
      wr_ret_address = tbl[i].wra; rd_ret_address = tbl[i].rda; rd_ret_data = tbl[i].rdd;
      #1;
      chk($sformatf("v%0d gnt", i), {a_gnt, b_gnt}, tbl[i].gnt);
      cyc();
      chk($sformatf("v%0d wr_en", i), wr_en, tbl[i].wr_en);
      chk($sformatf("v%0d wr_address", i), wr_address, tbl[i].wr_addr);
      chk($sformatf("v%0d wr_data", i), wr_data, tbl[i].wr_data);
      chk($sformatf("v%0d rd_en", i), rd_en, tbl[i].rd_en);
      chk($sformatf("v%0d rd_address", i), rd_address, tbl[i].rd_addr);
      chk($sformatf("v%0d ret flags", i), {a_wr_done, b_wr_done, a_rd_valid, b_rd_valid},
          tbl[i].ret);
      chk($sformatf("v%0d a_ret_address", i), a_ret_address, tbl[i].a_ret);
      chk($sformatf("v%0d b_ret_address", i), b_ret_address, tbl[i].b_ret);
      chk($sformatf("v%0d a_rd_data", i), a_rd_data, tbl[i].a_rd);
      chk($sformatf("v%0d b_rd_data", i), b_rd_data, tbl[i].b_rd);
      chk($sformatf("v%0d spurious", i), spurious_err, 0);
    end
    idle_in();

    // Fill the read FIFO from A; the fifth read blocks while writes still go through.
    for (int i = 0; i < 4; i++) begin
      a_req = 1; a_we = 0; a_address = 16'(16'h0100 + i);
      #1; chk($sformatf("fill%0d a_gnt", i), a_gnt, 1);
      cyc();
    end
    a_address = 16'h0104; b_req = 1; b_we = 1; b_address = 16'h0200; b_data = 16'h0BBB;
    #1; chk("full a_gnt", a_gnt, 0); chk("full b_gnt", b_gnt, 1);
    cyc();
    chk("full wr_en", wr_en, 1); chk("full wr_address", wr_address, 16'h0200);
    chk("full rd_en", rd_en, 0);
    b_req = 0; rd_ret_ack = 1; rd_ret_address = 16'h0100; rd_ret_data = 16'h0D00;
    #1; chk("nobypass a_gnt", a_gnt, 0);
    cyc();
    chk("pop0 a_rd_valid", a_rd_valid, 1); chk("pop0 a_rd_data", a_rd_data, 16'h0D00);
    chk("pop0 a_ret_address", a_ret_address, 16'h0100);
    rd_ret_ack = 0;
    #1; chk("resume a_gnt", a_gnt, 1);
    cyc();
    chk("resume rd_en", rd_en, 1); chk("resume rd_address", rd_address, 16'h0104);
    chk("pulse a_rd_valid", a_rd_valid, 0);
    // One pop, then push+pop together: count must end at 3, so one more push fills it.
    a_req = 0; rd_ret_ack = 1; rd_ret_address = 16'h0101;
    cyc();
    a_req = 1; a_address = 16'h0106; rd_ret_address = 16'h0102;
    #1; chk("pushpop a_gnt", a_gnt, 1);
    cyc();
    rd_ret_ack = 0; a_address = 16'h0107;
    #1; chk("refill a_gnt", a_gnt, 1);
    cyc();
    a_address = 16'h0108;
    #1; chk("refull a_gnt", a_gnt, 0);
    cyc();
    a_req = 0;
    drain[0] = 16'h0103; drain[1] = 16'h0104; drain[2] = 16'h0106; drain[3] = 16'h0107;
    for (int k = 0; k < 4; k++) begin
      rd_ret_ack = 1; rd_ret_address = drain[k]; rd_ret_data = drain[k] ^ 16'hF000;
      cyc();
      chk($sformatf("drain%0d a_rd_valid", k), a_rd_valid, 1);
      chk($sformatf("drain%0d b_rd_valid", k), b_rd_valid, 0);
      chk($sformatf("drain%0d a_rd_data", k), a_rd_data, drain[k] ^ 16'hF000);
    end
    rd_ret_ack = 0;

    // B's write completes, then an extra write ack is spurious and sticky.
    wr_ret_ack = 1; wr_ret_address = 16'h0200;
    cyc();
    chk("bwr b_wr_done", b_wr_done, 1); chk("bwr a_wr_done", a_wr_done, 0);
    chk("bwr b_ret_address", b_ret_address, 16'h0200); chk("bwr spurious", spurious_err, 0);
    wr_ret_address = 16'h0999;
    cyc();
    chk("spur set", spurious_err, 1);
    chk("spur done flags", {a_wr_done, b_wr_done}, 0);
    wr_ret_ack = 0;
    cyc(); cyc();
    chk("spur sticky", spurious_err, 1);
    a_req = 1; a_we = 1; a_address = 16'h0A00; a_data = 16'h0001;
    #1; chk("post-spur a_gnt", a_gnt, 1);
    cyc();
    a_req = 0; wr_ret_ack = 1; wr_ret_address = 16'h0A00;
    cyc();
    chk("post-spur a_wr_done", a_wr_done, 1);
    wr_ret_ack = 0;
    reset = 1;
    #1; chk("reset clears spurious", spurious_err, 0);
    cyc();
    reset = 0;
    cyc();

    // Reset with three reads in flight: later returns are dropped and flagged.
    for (int i = 0; i < 3; i++) begin
      a_req = 1; a_we = 0; a_address = 16'(16'h0300 + i);
      #1; chk($sformatf("inflight%0d a_gnt", i), a_gnt, 1);
      cyc();
    end
    idle_in();
    reset = 1;
    #1; chk("midrst rd_en", rd_en, 0);
    cyc();
    reset = 0;
    rd_ret_ack = 1; rd_ret_address = 16'h0300; rd_ret_data = 16'h7777;
    cyc();
    chk("stale a_rd_valid", a_rd_valid, 0);
    chk("stale spurious", spurious_err, 1);
    rd_ret_ack = 0;
    a_req = 1; a_address = 16'h0400; b_req = 1; b_we = 0; b_address = 16'h0500;
    #1; chk("tie after reset", {a_gnt, b_gnt}, 2'b10);
    cyc();
    chk("tie rd_address", rd_address, 16'h0400);
    idle_in();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
